// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding, MMIO addresses.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_e;

    localparam logic [31:0] DISPLAY_ADDR = 32'd1024;
    localparam logic [31:0] LEVERS_ADDR  = 32'd1028;

    // Byte strobes for a store; unknown widths are treated as a full word.
    function automatic logic [3:0] store_strobe(input logic [2:0] funct3);
        logic [3:0] strobe;
        case (funct3)
            F3_B:    strobe = 4'b0001;
            F3_H:    strobe = 4'b0011;
            default: strobe = 4'b1111;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of raw load data according to RV32I funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] extended
);

    always_comb begin
        extended = raw;
        case (funct3)
            F3_B:    extended = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   extended = {24'd0, raw[7:0]};
            F3_H:    extended = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   extended = {16'd0, raw[15:0]};
            default: extended = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and the byte-banked RAM manager.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter logic [31:0] DISPLAY_ADDR = lsu_pkg::DISPLAY_ADDR,
    parameter logic [31:0] IDLE_ADDR    = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] memaddr,
    output logic [31:0] memin,
    output logic [3:0]  writeEnables,
    input  logic [31:0] memout
);
    import lsu_pkg::*;

    lsu_state_e  state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic        r_skip;
    logic        r_fault;
    logic        misalign;
    logic        display_load;
    logic [31:0] extended;

    lsu_load_extend u_extend (
        .funct3   (r_funct3),
        .raw      (memout),
        .extended (extended)
    );

    // Loads from the display register must never reach memaddr.
    assign display_load = !req_write && (req_addr == DISPLAY_ADDR);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (req_funct3)
            F3_H, F3_HU: misalign = req_addr[0];
            F3_W:        misalign = |req_addr[1:0];
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_fault   <= 1'b0;
            memaddr      <= IDLE_ADDR;
            memin        <= 32'd0;
            writeEnables <= 4'd0;
            r_write      <= 1'b0;
            r_funct3     <= F3_W;
            r_skip       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_ACCESS;
                        req_ready <= 1'b0;
                        r_write   <= req_write;
                        r_funct3  <= req_funct3;
                        r_skip    <= misalign;
                        r_fault   <= misalign || display_load;
                        memaddr   <= (misalign || display_load) ? IDLE_ADDR : req_addr;
                        if (req_write && !misalign) begin
                            memin        <= req_wdata;
                            writeEnables <= store_strobe(req_funct3);
                        end
                    end
                end
                S_ACCESS: begin
                    memin        <= 32'd0;
                    writeEnables <= 4'd0;
                    // Stores and trapped accesses need no read-latency cycle.
                    if (r_write || r_skip) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_fault <= r_fault;
                        memaddr    <= IDLE_ADDR;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= r_fault ? 32'd0 : extended;
                    resp_fault <= r_fault;
                    memaddr    <= IDLE_ADDR;
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset abort, random vs. reference model.
module tb_load_store_unit;

    localparam logic [31:0] DISP   = 32'd1024;
    localparam logic [31:0] LEVERS = 32'd1028;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] memaddr;
    logic [31:0] memin;
    logic [3:0]  writeEnables;
    logic [31:0] memout;

    int checks = 0;
    int errors = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .memaddr(memaddr), .memin(memin), .writeEnables(writeEnables), .memout(memout)
    );

    always #5 clk = ~clk;

    // RAM manager environment: byte lanes rotated to memaddr, 1-cycle sync read, display + levers MMIO.
    logic [7:0]  ram [0:4095];
    logic [31:0] display_reg;
    logic [31:0] levers_val;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (writeEnables[i]) ram[12'(memaddr[10:0]) + 12'(i)] <= memin[8*i +: 8];
        end
        if (memaddr == DISP) display_reg <= memin;
        if (memaddr == LEVERS) memout <= levers_val;
        else memout <= {ram[12'(memaddr[10:0]) + 12'd3], ram[12'(memaddr[10:0]) + 12'd2],
                        ram[12'(memaddr[10:0]) + 12'd1], ram[12'(memaddr[10:0])]};
    end

    // Reference model state.
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] ref_display;

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] w);
        int v;
        case (f3)
            3'd0: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
            3'd1: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
            3'd4: return w & 32'hFF;
            3'd5: return w & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic model_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
        return 1'b0;
`else
        return (f3 == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int store_bytes(input logic [2:0] f3);
        return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 4; i++) w = w | (32'(ref_mem[12'(a[10:0]) + 12'(i)]) << (8 * i));
        return w;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        if (model_trap(f3, a)) return;
        for (int i = 0; i < store_bytes(f3); i++) ref_mem[12'(a[10:0]) + 12'(i)] = 8'(wd >> (8 * i));
        if (a == DISP) ref_display = wd;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One transaction; cycle 1 is the ACCESS cycle right after the accept edge.
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                           output int lat, output logic [3:0] we1, output logic [31:0] ma1,
                           output logic saw_disp, output logic [31:0] ma_resp);
        int n = 0;
        rd = 32'hX; flt = 1'bx; lat = -1; we1 = 4'hX; ma1 = 32'hX; saw_disp = 1'b0; ma_resp = 32'hX;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check32("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = DISP; req_write = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin we1 = writeEnables; ma1 = memaddr; end
            if (!wr && memaddr == DISP) saw_disp = 1'b1;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; flt = resp_fault; ma_resp = memaddr;
                break;
            end
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        flt;
        int          lat;
        logic [3:0]  we;
        logic [31:0] ma;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd, ma1, ma_resp, exp_rd;
        logic flt, saw, trap, exp_flt;
        logic [3:0] we1, exp_we;
        int lat;
        logic wr;
        logic [2:0] f3;
        logic [31:0] a, wd;
        logic [2:0] load_f3 [5];

        load_f3[0] = 3'd0; load_f3[1] = 3'd1; load_f3[2] = 3'd2; load_f3[3] = 3'd4; load_f3[4] = 3'd5;
        for (int i = 0; i < 4096; i++) begin ram[i] = 8'd0; ref_mem[i] = 8'd0; end
        display_reg = 32'd0; ref_display = 32'd0; levers_val = 32'h0000_00A5; memout = 32'd0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

        vecs[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 4'hF, 32'h10};
        vecs[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3, 4'h0, 32'h10};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[2]  = '{1'b0, 3'd2, 32'h12,  32'h0,        32'h0,        1'b1, 2, 4'h0, 32'h0};
`else
        vecs[2]  = '{1'b0, 3'd2, 32'h12,  32'h0,        32'h0000DEAD, 1'b0, 3, 4'h0, 32'h12};
`endif
        vecs[3]  = '{1'b1, 3'd0, 32'h21,  32'h000000F0, 32'h0,        1'b0, 2, 4'h1, 32'h21};
        vecs[4]  = '{1'b0, 3'd0, 32'h21,  32'h0,        32'hFFFFFFF0, 1'b0, 3, 4'h0, 32'h21};
        vecs[5]  = '{1'b0, 3'd4, 32'h21,  32'h0,        32'h000000F0, 1'b0, 3, 4'h0, 32'h21};
        vecs[6]  = '{1'b1, 3'd1, 32'h30,  32'h00008001, 32'h0,        1'b0, 2, 4'h3, 32'h30};
        vecs[7]  = '{1'b0, 3'd1, 32'h30,  32'h0,        32'hFFFF8001, 1'b0, 3, 4'h0, 32'h30};
        vecs[8]  = '{1'b0, 3'd5, 32'h30,  32'h0,        32'h00008001, 1'b0, 3, 4'h0, 32'h30};
        vecs[9]  = '{1'b0, 3'd2, DISP,    32'h0,        32'h0,        1'b1, 3, 4'h0, 32'h0};
        vecs[10] = '{1'b1, 3'd2, DISP,    32'h5,        32'h0,        1'b0, 2, 4'hF, DISP};
        vecs[11] = '{1'b0, 3'd2, LEVERS,  32'h0,        32'h000000A5, 1'b0, 3, 4'h0, LEVERS};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_req_ready", 32'(req_ready), 32'd1);
        check32("rst_resp_valid", 32'(resp_valid), 32'd0);
        check32("rst_resp_rdata", resp_rdata, 32'd0);
        check32("rst_resp_fault", 32'(resp_fault), 32'd0);
        check32("rst_memaddr", memaddr, 32'd0);
        check32("rst_memin", memin, 32'd0);
        check32("rst_we", 32'(writeEnables), 32'd0);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, lat, we1, ma1, saw, ma_resp);
            check32($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            check32($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].flt));
            check32($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check32($sformatf("vec%0d_we", i), 32'(we1), 32'(vecs[i].we));
            check32($sformatf("vec%0d_memaddr", i), ma1, vecs[i].ma);
            check32($sformatf("vec%0d_resp_memaddr", i), ma_resp, 32'd0);
            if (vecs[i].wr) model_store(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].wr && vecs[i].addr == DISP) begin
                check32("disp_load_addr_seen", 32'(saw), 32'd0);
                check32("disp_load_display", display_reg, 32'd0);
                @(negedge clk);
                check32("fault_hold", 32'(resp_fault), 32'd1);
            end
            if (vecs[i].wr && vecs[i].addr == DISP) check32("disp_store_display", display_reg, 32'd5);
        end

        // Reset during the ACCESS cycle of a store aborts it.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check32("abort_access_we", 32'(writeEnables), 32'hF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check32("abort_we", 32'(writeEnables), 32'd0);
        check32("abort_resp_valid", 32'(resp_valid), 32'd0);
        check32("abort_memaddr", memaddr, 32'd0);
        check32("abort_memin", memin, 32'd0);
        check32("abort_fault", 32'(resp_fault), 32'd0);
        check32("abort_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check32("abort_ready_after", 32'(req_ready), 32'd1);
        begin
            int stray = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (resp_valid || writeEnables != 4'd0) stray++;
            end
            check32("abort_no_stray_activity", 32'(stray), 32'd0);
        end

        // Randomized transactions against the reference model.
        for (int t = 0; t < 300; t++) begin
            int sel = int'($urandom_range(15, 0));
            wr = 1'(($urandom_range(1, 0)));
            f3 = wr ? 3'($urandom_range(2, 0)) : load_f3[$urandom_range(4, 0)];
            a  = 32'($urandom_range(63, 0));
            wd = $urandom;
            if (sel == 0) a = DISP;
            if (sel == 1) begin a = LEVERS; wr = 1'b0; f3 = load_f3[$urandom_range(4, 0)]; end
            if (sel == 2) levers_val = $urandom;
            trap = model_trap(f3, a);
            exp_flt = trap || (!wr && a == DISP);
            if (wr || exp_flt) exp_rd = 32'd0;
            else if (a == LEVERS) exp_rd = model_ext(f3, levers_val);
            else exp_rd = model_ext(f3, model_word(a));
            exp_we = (wr && !trap) ? ((f3 == 3'd0) ? 4'h1 : (f3 == 3'd1) ? 4'h3 : 4'hF) : 4'h0;
            run_txn(wr, f3, a, wd, rd, flt, lat, we1, ma1, saw, ma_resp);
            check32($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            check32($sformatf("rnd%0d_fault", t), 32'(flt), 32'(exp_flt));
            check32($sformatf("rnd%0d_latency", t), 32'(lat), (wr || trap) ? 32'd2 : 32'd3);
            check32($sformatf("rnd%0d_we", t), 32'(we1), 32'(exp_we));
            check32($sformatf("rnd%0d_memaddr", t), ma1, exp_flt ? 32'd0 : a);
            check32($sformatf("rnd%0d_disp_seen", t), 32'(saw), 32'd0);
            if (wr) model_store(f3, a, wd);
        end
        check32("final_display", display_reg, ref_display);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the byte-banked RAM manager.
- Accepts one load or store request per transaction over a valid/ready handshake.
- Drives the manager's `memaddr`, `memin` and `writeEnables` for exactly the required cycles and holds the address across the one-cycle synchronous RAM read latency.
- Returns sign- or zero-extended load data, or store completion, on a one-cycle response pulse.

Parameters:
- DISPLAY_ADDR, 32'd1024, memory-mapped display register address. The manager latches `memin` into the display whenever `memaddr` equals it, regardless of the write enables.
- IDLE_ADDR, 32'd0, address driven on `memaddr` whenever no access is in flight.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data (0 for stores).
- resp_fault  out  1  access suppressed (see Optional Feature / display rule).
- memaddr  out  32  to the RAM manager.
- memin  out  32  to the RAM manager, unshifted.
- writeEnables  out  4  byte strobes, lane 0 = addressed byte.
- memout  in  32  from the RAM manager; byte at `memaddr` in [7:0].

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; `req_ready`=1; `resp_valid`=0; `resp_rdata`=0; `resp_fault`=0; `memaddr`=IDLE_ADDR; `memin`=0; `writeEnables`=0.
- Reset mid-transaction aborts it. No write strobe is issued after the reset edge, and no response is produced.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: `req_ready`=1.
  - `req_valid`=1 registers write, funct3, addr and wdata, then moves to ACCESS.
  - `req_valid` is ignored in every other state.
- ACCESS (1 cycle): `memaddr`=registered addr.
  - Store: `memin`=wdata; `writeEnables`=0001 for B, 0011 for H, 1111 for W (any other funct3 is treated as W). Next state RESP.
  - Load: `writeEnables`=0000. Next state WAIT.
- WAIT (load only, 1 cycle): `memaddr` held, `writeEnables`=0.
  - Capture extended `memout` into `resp_rdata` at the end of the cycle. Next state RESP.
  - B: bits [7:0] sign-extended. BU: zero-extended. H: bits [15:0] sign-extended. HU: zero-extended. W or other funct3: all 32 bits.
- RESP (1 cycle): `resp_valid`=1; `memaddr`=IDLE_ADDR; `writeEnables`=0. Next state IDLE.
- Latency, accept edge to `resp_valid`: store 2 cycles, load 3 cycles.
- Throughput: one transaction per 3 (store) or 4 (load) cycles. There is no response backpressure.
- Display protection: a load whose addr equals DISPLAY_ADDR is never driven onto `memaddr`; IDLE_ADDR is held instead. It completes with the normal load latency, `resp_rdata`=0 and `resp_fault`=1.
- Stores to DISPLAY_ADDR are issued normally, so the display updates.
- `resp_fault` and `resp_rdata` hold their values until the next RESP or reset.
- `memaddr` equals a request address only in ACCESS and WAIT.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]≠0, skips the memory access.
  - Goes IDLE→ACCESS→RESP with `writeEnables`=0 and `memaddr`=IDLE_ADDR.
  - Responds with `resp_fault`=1, `resp_rdata`=0.
- Undefined: misaligned accesses are issued unchanged; the RAM manager's lane rotation services them. `resp_fault` is driven only by display protection.

Decomposition:
- Shared package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding (2-bit IDLE/ACCESS/WAIT/RESP);
  - MMIO address constants DISPLAY_ADDR 1024 and LEVERS_ADDR 1028.
- One combinational sub-module `lsu_load_extend` (funct3 + 32-bit raw in, 32-bit extended out), reused for the WAIT capture.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF: ACCESS cycle shows `writeEnables`=1111, `memaddr`=0x10; `resp_valid` 2 cycles after accept. A following LW addr 0x10 returns 0xDEADBEEF 3 cycles after accept.
- SB addr 0x21 data 0x000000F0 → `writeEnables`=0001, `memaddr`=0x21. LB 0x21 → 0xFFFFFFF0; LBU 0x21 → 0x000000F0.
- SH addr 0x30 data 0x8001 → `writeEnables`=0011. LH → 0xFFFF8001; LHU → 0x00008001.
- LW 1024 → `memaddr` never equals 1024, `resp_fault`=1, `resp_rdata`=0, display unchanged. SW 1024 data 0x5 → display = 5. LW 1028 with levers = 0xA5 → 0x000000A5.
- rst_n low during the ACCESS cycle of an SW → no `writeEnables` after the reset edge, no `resp_valid`, outputs at reset values, `req_ready`=1 next cycle.
- LW addr 0x12: with LSU_MISALIGN_TRAP_EN, `resp_fault`=1, no access, and response 2 cycles after accept. Without it, the access is issued at 0x12 and the RAM word is returned.
